// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding, reset constants and counter sizing for piso_serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_BIT   = 1'b0;

    // Counter must hold FRAME_LEN-1; never narrower than one bit.
    function automatic int cnt_width(input int frame_len);
        return (frame_len <= 2) ? 1 : $clog2(frame_len);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, MSB-first serial-out transmitter.
// Define PISO_PARITY_EN to append an even-parity bit after the data LSB.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_q,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = cnt_width(FRAME_LEN);

    state_t                 r_state, w_state_nx;
    logic [FRAME_LEN-1:0]   r_shift, w_shift_nx, w_frame;
    logic [CW-1:0]          r_cnt, w_cnt_nx;
    logic                   w_xfer;

    // Parity rides in the shift register's LSB so it leaves right after the data LSB.
`ifdef PISO_PARITY_EN
    assign w_frame = {load_data, ^load_data};
`else
    assign w_frame = load_data;
`endif

    assign ser_valid  = (r_state == SHIFT);
    assign busy       = (r_state == SHIFT);
    assign ser_last   = (r_state == SHIFT) && (r_cnt == '0);
    assign load_ready = (r_state == IDLE) || ser_last;
    assign ser_q      = r_shift[FRAME_LEN-1];
    assign w_xfer     = load_valid && load_ready;

    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_cnt_nx   = r_cnt;
        if (w_xfer) begin
            w_state_nx = SHIFT;
            w_shift_nx = w_frame;
            w_cnt_nx   = CW'(FRAME_LEN - 1);
        end else if (r_state == SHIFT) begin
            w_shift_nx = r_shift << 1;
            w_cnt_nx   = ser_last ? '0 : r_cnt - CW'(1);
            w_state_nx = ser_last ? IDLE : SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= RST_STATE;
            r_shift <= {FRAME_LEN{RST_BIT}};
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_shift <= w_shift_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench; expected serial bits queued on each accepted load.
// Honours PISO_PARITY_EN the same way the design does.
module tb_piso_serializer;

    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             clear;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_q;
    logic             ser_valid;
    logic             ser_last;
    logic             busy;

    int   n_chk = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit   acc = 1'b0;
    bit   sb[$];

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .clear      (clear),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .ser_q      (ser_q),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: one queued bit is consumed per edge; a load is taken when
    // at most the final bit of a frame remains.
    always @(posedge clk) begin
        bit rdy;
        acc = 1'b0;
        if (clear) begin
            sb.delete();
        end else begin
            rdy = (sb.size() <= 1);
            if (sb.size() > 0) void'(sb.pop_front());
            if (load_valid && rdy) begin
                for (int i = WIDTH - 1; i >= 0; i--) sb.push_back(load_data[i]);
`ifdef PISO_PARITY_EN
                sb.push_back(^load_data);
`endif
                acc = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            int n;
            n = sb.size();
            chk("valid", 64'(ser_valid), 64'(n > 0));
            chk("busy",  64'(busy),      64'(n > 0));
            chk("ready", 64'(load_ready), 64'(n <= 1));
            chk("last",  64'(ser_last),  64'(n == 1));
            chk("q",     64'(ser_q),     (n > 0) ? 64'(sb[0]) : 64'd0);
        end
    end

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send(input logic [WIDTH-1:0] d);
        int t;
        load_valid = 1'b1;
        load_data  = d;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!acc && t < 200);
        if (!acc) chk("accept_timeout", 64'(t), 64'd0);
    endtask

    task automatic idle(input int n);
        load_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        clear      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        idle(2);
        // Load presented together with clear must be dropped.
        clear = 1'b1;
        load_valid = 1'b1;
        load_data = 8'hC3;
        @(negedge clk);
        clear = 1'b0;
        idle(2);
        send(8'hA5);
        idle(FRAME_LEN + 2);
        send(8'hA5);
        send(8'h3C);
        idle(FRAME_LEN + 2);
        send(8'h00);
        load_valid = 1'b0;
        repeat (2) @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'hFF;
        @(negedge clk);
        idle(FRAME_LEN + 2);
        send(8'hA5);
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_valid", 64'(ser_valid), 64'd0);
        chk("clr_ready", 64'(load_ready), 64'd1);
        send(8'h81);
        idle(FRAME_LEN + 2);
        send(8'h07);
        send(8'hFF);
        send(8'h01);
        idle(FRAME_LEN + 3);
        chk("drain", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
